hazard_ctrl: RTL and testbench
==============================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have port `clk`, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 SHALL have port `reset`, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have inputs `Match_{1,2,3,0}E_{M,W,M0,W0}`, 1 bit each (16 total): Execute-stage source register equals the M/W primary (WA3) or secondary (WA0) destination.
REQ-004 SHALL have input `Match_12D_E`, 1 bit: a Decode source equals the Execute destination.
REQ-005 SHALL have inputs `RegWriteM`, `RegWrite2M`, `RegWriteW`, `RegWrite2W`, 1 bit each: primary/secondary write enables in Memory and Writeback.
REQ-006 SHALL have inputs `MemtoRegE` (1 bit: load in Execute) and `BranchTakenE` (1 bit: branch resolved taken).
REQ-007 SHALL have inputs `MultiStartE` (1 bit: multi-cycle ALU op entering Execute) and `MultiCyclesE` (4 bits: total Execute cycles of that op).
REQ-008 SHALL have outputs `ForwardAE`, `ForwardBE`, `ForwardCE`, `ForwardDE`, 3 bits each: forwarding mux selects for sources 1, 2, 0 and 3.
REQ-009 SHALL have outputs `StallF`, `StallD`, `StallE`, 1 bit each: register enables for PC, IF/ID and ID/EX; 1 = load, 0 = hold.
REQ-010 SHALL have outputs `FlushD`, `FlushE`, `FlushM`, 1 bit each: synchronous clears of IF/ID, ID/EX and EX/MEM.
REQ-011 SHALL have output `BusyE`, 1 bit: multi-cycle op in progress.
REQ-012 SHALL have outputs `StallCount` and `FlushCount`, 16 bits each: event counters.

Function
REQ-013 SHALL compute each Forward select combinationally with priority: 3'd2 if Match_xE_M & RegWriteM; else 3'd3 if Match_xE_M0 & RegWrite2M; else 3'd1 if Match_xE_W & RegWriteW; else 3'd4 if Match_xE_W0 & RegWrite2W; else 3'd0.
REQ-014 SHALL never drive Forward codes 3'd5 to 3'd7.
REQ-015 SHALL compute forwarding in every state, including BUSY.
REQ-016 SHALL use a two-state FSM, IDLE and BUSY, with a 4-bit down-counter `cnt`.
REQ-017 In IDLE, MultiStartE with MultiCyclesE >= 2 SHALL move to BUSY and load cnt = MultiCyclesE - 1.
REQ-018 In IDLE, MultiStartE with MultiCyclesE of 0 or 1 SHALL be treated as single-cycle: no state change and no stall.
REQ-019 In BUSY, cnt SHALL decrement each cycle; the cycle with cnt = 1 SHALL return to IDLE.
REQ-020 A start with N cycles SHALL therefore occupy Execute for exactly N cycles.
REQ-021 BusyE SHALL equal (state == BUSY).
REQ-022 In BUSY: StallF = StallD = StallE = 0, FlushM = 1, FlushD = FlushE = 0.
REQ-023 In BUSY, BranchTakenE and Match_12D_E SHALL be ignored.
REQ-024 On the exit cycle (BUSY -> IDLE), FlushM SHALL be 0 and the op result SHALL advance.
REQ-025 In IDLE, a load-use hazard (Match_12D_E & MemtoRegE) SHALL give StallF = StallD = 0, FlushE = 1, StallE = 1.
REQ-026 In IDLE, BranchTakenE SHALL give FlushD = FlushE = 1 and StallF = StallD = 1.
REQ-027 When BranchTakenE and a load-use hazard occur together, the branch SHALL win: flush only, no stall.
REQ-028 When MultiStartE and BranchTakenE occur together in IDLE, MultiStartE SHALL take effect and the branch flush SHALL also apply that cycle.
REQ-029 Otherwise all Stall outputs SHALL be 1 and all Flush outputs 0.

Reset
REQ-030 On reset the FSM SHALL go to IDLE and cnt = 0, including mid-BUSY (the op is abandoned).
REQ-031 During reset, Stall outputs SHALL be 1, Flush outputs 0 and BusyE 0.
REQ-032 On reset, StallCount and FlushCount SHALL be cleared to 0.

Configuration
REQ-033 Macro HAZARD_PERF_EN defined: StallCount SHALL increment each cycle StallD == 0, and FlushCount each cycle FlushE | FlushM == 1.
REQ-034 With HAZARD_PERF_EN, both counters SHALL saturate at 16'hFFFF.
REQ-035 Macro HAZARD_PERF_EN undefined: both counter ports SHALL exist, be tied to 16'h0000, and no counter flops SHALL be instantiated.

Verification
REQ-036 Forward priority: Match_1E_M = Match_1E_W = 1, RegWriteM = RegWriteW = 1 -> ForwardAE = 3'd2; then RegWriteM = 0 -> 3'd1; then only Match_1E_W0 & RegWrite2W -> 3'd4.
REQ-037 Load-use: MemtoRegE = 1, Match_12D_E = 1 in IDLE -> StallF = StallD = 0, FlushE = 1 for that cycle only.
REQ-038 Branch vs load-use: BranchTakenE = MemtoRegE = Match_12D_E = 1 -> FlushD = FlushE = 1, StallF = StallD = 1.
REQ-039 Multi-cycle: MultiStartE = 1, MultiCyclesE = 4 -> BusyE high for 3 cycles, FlushM = 1 for those 3, StallE = 0; 4th cycle IDLE with all Stall = 1.
REQ-040 Reset at 2nd BUSY cycle of a MultiCyclesE = 8 op -> next cycle IDLE, BusyE = 0, counters 0; MultiCyclesE = 1 start -> BusyE never asserts.
REQ-041 With HAZARD_PERF_EN: hold load-use for 70000 cycles -> StallCount = 16'hFFFF; without the macro -> StallCount = 16'h0000.

Source files
------------

// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl -- pipeline hazard unit for a dual-write-port pipeline.
//
// Purpose:
//   * Forwarding selects for the four Execute-stage sources (1, 2, 0, 3).
//     Each select chooses from the Memory and Writeback primary (WA3) and
//     secondary (WA0) results, with a fixed priority.
//   * Stall and flush control for load-use hazards, taken branches and
//     multi-cycle Execute operations. The multi-cycle control is an
//     IDLE/BUSY FSM with a 4-bit down-counter.
//   * Optional performance counters for stall and flush cycles.
//
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   Match_{1,2,3,0}E_{M,W,M0,W0}    Execute source matches a M/W destination
//   Match_12D_E                     a Decode source matches the Execute dest
//   RegWriteM/2M/W/2W               primary/secondary write enables in M and W
//   MemtoRegE, BranchTakenE         load in E, branch resolved taken
//   MultiStartE, MultiCyclesE[3:0]  multi-cycle op start and its total cycles
//   ForwardAE/BE/CE/DE[2:0]         forwarding selects for sources 1, 2, 0, 3
//   StallF/D/E                      register load enables (1 = load, 0 = hold)
//   FlushD/E/M                      synchronous clears of IF/ID, ID/EX, EX/MEM
//   BusyE                           multi-cycle op in progress
//   StallCount, FlushCount[15:0]    event counters
//
// Configuration:
//   HAZARD_PERF_EN  When defined, StallCount counts cycles with StallD == 0
//                   and FlushCount counts cycles with FlushE | FlushM. Both
//                   counters saturate at 16'hFFFF. When undefined, both ports
//                   are tied to zero and the design has no counter flops.
// -----------------------------------------------------------------------------

// Per-source forwarding select. Priority is M primary, M secondary,
// W primary, W secondary. Only codes 0..4 can come out.
module hazard_fwd_sel (
    input  logic       match_m,
    input  logic       match_m0,
    input  logic       match_w,
    input  logic       match_w0,
    input  logic       we_m,
    input  logic       we2_m,
    input  logic       we_w,
    input  logic       we2_w,
    output logic [2:0] fwd_sel
);
    always_comb begin
        fwd_sel = 3'd0;
        if (match_m && we_m)
            fwd_sel = 3'd2;
        else if (match_m0 && we2_m)
            fwd_sel = 3'd3;
        else if (match_w && we_w)
            fwd_sel = 3'd1;
        else if (match_w0 && we2_w)
            fwd_sel = 3'd4;
    end
endmodule

module hazard_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        Match_1E_M,
    input  logic        Match_1E_W,
    input  logic        Match_1E_M0,
    input  logic        Match_1E_W0,
    input  logic        Match_2E_M,
    input  logic        Match_2E_W,
    input  logic        Match_2E_M0,
    input  logic        Match_2E_W0,
    input  logic        Match_3E_M,
    input  logic        Match_3E_W,
    input  logic        Match_3E_M0,
    input  logic        Match_3E_W0,
    input  logic        Match_0E_M,
    input  logic        Match_0E_W,
    input  logic        Match_0E_M0,
    input  logic        Match_0E_W0,
    input  logic        Match_12D_E,
    input  logic        RegWriteM,
    input  logic        RegWrite2M,
    input  logic        RegWriteW,
    input  logic        RegWrite2W,
    input  logic        MemtoRegE,
    input  logic        BranchTakenE,
    input  logic        MultiStartE,
    input  logic [3:0]  MultiCyclesE,
    output logic [2:0]  ForwardAE,
    output logic [2:0]  ForwardBE,
    output logic [2:0]  ForwardCE,
    output logic [2:0]  ForwardDE,
    output logic        StallF,
    output logic        StallD,
    output logic        StallE,
    output logic        FlushD,
    output logic        FlushE,
    output logic        FlushM,
    output logic        BusyE,
    output logic [15:0] StallCount,
    output logic [15:0] FlushCount
);
    localparam int NUM_SRC = 4;

    // ---------------------------------------------------------------------
    // Forwarding. Lanes map to the outputs: 0 = A (src1), 1 = B (src2),
    // 2 = C (src0), 3 = D (src3). Forwarding does not depend on the FSM
    // state, so it stays active while a multi-cycle op is running.
    // ---------------------------------------------------------------------
    logic [NUM_SRC-1:0]      m_m, m_m0, m_w, m_w0;
    logic [NUM_SRC-1:0][2:0] fwd;

    assign m_m  = {Match_3E_M,  Match_0E_M,  Match_2E_M,  Match_1E_M};
    assign m_m0 = {Match_3E_M0, Match_0E_M0, Match_2E_M0, Match_1E_M0};
    assign m_w  = {Match_3E_W,  Match_0E_W,  Match_2E_W,  Match_1E_W};
    assign m_w0 = {Match_3E_W0, Match_0E_W0, Match_2E_W0, Match_1E_W0};

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_fwd
        hazard_fwd_sel u_sel (
            .match_m  (m_m[g]),
            .match_m0 (m_m0[g]),
            .match_w  (m_w[g]),
            .match_w0 (m_w0[g]),
            .we_m     (RegWriteM),
            .we2_m    (RegWrite2M),
            .we_w     (RegWriteW),
            .we2_w    (RegWrite2W),
            .fwd_sel  (fwd[g])
        );
    end

    assign ForwardAE = fwd[0];
    assign ForwardBE = fwd[1];
    assign ForwardCE = fwd[2];
    assign ForwardDE = fwd[3];

    // ---------------------------------------------------------------------
    // Multi-cycle FSM. The start cycle is an ordinary IDLE cycle. BUSY then
    // lasts for N-1 cycles, so the op holds Execute for N cycles in total.
    // On the first IDLE cycle after BUSY, FlushM is low and the result
    // moves on into Memory.
    // ---------------------------------------------------------------------
    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       load_use;

    assign load_use = Match_12D_E & MemtoRegE;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        StallF  = 1'b1;
        StallD  = 1'b1;
        StallE  = 1'b1;
        FlushD  = 1'b0;
        FlushE  = 1'b0;
        FlushM  = 1'b0;
        BusyE   = 1'b0;

        case (state_q)
            IDLE: begin
                if (MultiStartE && (MultiCyclesE >= 4'd2)) begin
                    state_d = BUSY;
                    cnt_d   = MultiCyclesE - 4'd1;
                end
                // A taken branch overrides a load-use hazard. The stalled
                // instruction sits on the wrong path and is flushed anyway.
                if (BranchTakenE) begin
                    FlushD = 1'b1;
                    FlushE = 1'b1;
                end else if (load_use) begin
                    StallF = 1'b0;
                    StallD = 1'b0;
                    FlushE = 1'b1;
                end
            end
            BUSY: begin
                // Freeze the front end and insert bubbles into Memory until
                // the op completes. Branch and load-use inputs come from
                // stale stages in this state, so they are ignored.
                BusyE  = 1'b1;
                StallF = 1'b0;
                StallD = 1'b0;
                StallE = 1'b0;
                FlushM = 1'b1;
                if (cnt_q <= 4'd1) begin
                    state_d = IDLE;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end
        endcase

        // While reset is asserted, the outputs show the quiescent pipeline
        // even if the state register has not been cleared yet.
        if (reset) begin
            state_d = IDLE;
            cnt_d   = 4'd0;
            StallF  = 1'b1;
            StallD  = 1'b1;
            StallE  = 1'b1;
            FlushD  = 1'b0;
            FlushE  = 1'b0;
            FlushM  = 1'b0;
            BusyE   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // ---------------------------------------------------------------------
    // Performance counters (saturating).
    // ---------------------------------------------------------------------
`ifdef HAZARD_PERF_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic [15:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (!StallD && (stall_cnt_q != 16'hFFFF))
            stall_cnt_d = stall_cnt_q + 16'd1;
        if ((FlushE || FlushM) && (flush_cnt_q != 16'hFFFF))
            flush_cnt_d = flush_cnt_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= 16'd0;
            flush_cnt_q <= 16'd0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign StallCount = stall_cnt_q;
    assign FlushCount = flush_cnt_q;
`else
    assign StallCount = 16'h0000;
    assign FlushCount = 16'h0000;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl. A behavioural model tracks the number
// of remaining BUSY cycles as an integer and derives the expected outputs
// from the hazard rules. Each scenario task checks the outputs against that
// model and against directed constants.
module tb_hazard_ctrl;
  logic clk = 1'b0;
  logic reset;
  logic [15:0] mv;
  logic RegWriteM, RegWrite2M, RegWriteW, RegWrite2W;
  logic MemtoRegE, BranchTakenE, Match_12D_E, MultiStartE;
  logic [3:0] MultiCyclesE;
  logic [2:0] ForwardAE, ForwardBE, ForwardCE, ForwardDE;
  logic StallF, StallD, StallE, FlushD, FlushE, FlushM, BusyE;
  logic [15:0] StallCount, FlushCount;

  // Match bits packed per source: [M, W, M0, W0] for src1, src2, src3, src0.
  logic Match_1E_M, Match_1E_W, Match_1E_M0, Match_1E_W0;
  logic Match_2E_M, Match_2E_W, Match_2E_M0, Match_2E_W0;
  logic Match_3E_M, Match_3E_W, Match_3E_M0, Match_3E_W0;
  logic Match_0E_M, Match_0E_W, Match_0E_M0, Match_0E_W0;
  assign {Match_1E_W0, Match_1E_M0, Match_1E_W, Match_1E_M} = mv[3:0];
  assign {Match_2E_W0, Match_2E_M0, Match_2E_W, Match_2E_M} = mv[7:4];
  assign {Match_3E_W0, Match_3E_M0, Match_3E_W, Match_3E_M} = mv[11:8];
  assign {Match_0E_W0, Match_0E_M0, Match_0E_W, Match_0E_M} = mv[15:12];

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  hazard_ctrl dut (
    .clk(clk), .reset(reset),
    .Match_1E_M(Match_1E_M), .Match_1E_W(Match_1E_W), .Match_1E_M0(Match_1E_M0), .Match_1E_W0(Match_1E_W0),
    .Match_2E_M(Match_2E_M), .Match_2E_W(Match_2E_W), .Match_2E_M0(Match_2E_M0), .Match_2E_W0(Match_2E_W0),
    .Match_3E_M(Match_3E_M), .Match_3E_W(Match_3E_W), .Match_3E_M0(Match_3E_M0), .Match_3E_W0(Match_3E_W0),
    .Match_0E_M(Match_0E_M), .Match_0E_W(Match_0E_W), .Match_0E_M0(Match_0E_M0), .Match_0E_W0(Match_0E_W0),
    .Match_12D_E(Match_12D_E),
    .RegWriteM(RegWriteM), .RegWrite2M(RegWrite2M), .RegWriteW(RegWriteW), .RegWrite2W(RegWrite2W),
    .MemtoRegE(MemtoRegE), .BranchTakenE(BranchTakenE),
    .MultiStartE(MultiStartE), .MultiCyclesE(MultiCyclesE),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .ForwardCE(ForwardCE), .ForwardDE(ForwardDE),
    .StallF(StallF), .StallD(StallD), .StallE(StallE),
    .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM),
    .BusyE(BusyE), .StallCount(StallCount), .FlushCount(FlushCount)
  );

  // ---------------- reference model ----------------
  // b = {W0, M0, W, M} for one source
  function automatic logic [2:0] m_fwd(input logic [3:0] b, input logic wm, input logic w2m,
                                       input logic ww, input logic w2w);
    if (b[0] && wm)  return 3'd2;
    if (b[2] && w2m) return 3'd3;
    if (b[1] && ww)  return 3'd1;
    if (b[3] && w2w) return 3'd4;
    return 3'd0;
  endfunction

  // {StallF, StallD, StallE, FlushD, FlushE, FlushM, BusyE}
  function automatic logic [6:0] m_ctrl(input logic rst, input int busy_left,
                                        input logic br, input logic lu);
    if (rst)           return 7'b1110000;
    if (busy_left > 0) return 7'b0000011;
    if (br)            return 7'b1111100;
    if (lu)            return 7'b0010100;
    return 7'b1110000;
  endfunction

  int          m_busy = 0;   // BUSY cycles still to come
  logic [15:0] m_sc = 16'd0;
  logic [15:0] m_fc = 16'd0;
  logic [6:0]  ec;
  logic [11:0] ef;
  logic [50:0] expv, dutv;

  assign ec = m_ctrl(reset, m_busy, BranchTakenE, MemtoRegE & Match_12D_E);
  assign ef = {m_fwd(mv[3:0],   RegWriteM, RegWrite2M, RegWriteW, RegWrite2W),
               m_fwd(mv[7:4],   RegWriteM, RegWrite2M, RegWriteW, RegWrite2W),
               m_fwd(mv[15:12], RegWriteM, RegWrite2M, RegWriteW, RegWrite2W),
               m_fwd(mv[11:8],  RegWriteM, RegWrite2M, RegWriteW, RegWrite2W)};
  assign expv = {ef, ec, m_sc, m_fc};
  assign dutv = {ForwardAE, ForwardBE, ForwardCE, ForwardDE,
                 StallF, StallD, StallE, FlushD, FlushE, FlushM, BusyE,
                 StallCount, FlushCount};

  always @(posedge clk) begin
    if (reset) begin
      m_busy <= 0;
      m_sc   <= 16'd0;
      m_fc   <= 16'd0;
    end else begin
      if (m_busy > 0) m_busy <= m_busy - 1;
      else if (MultiStartE && MultiCyclesE >= 4'd2) m_busy <= int'(MultiCyclesE) - 1;
`ifdef HAZARD_PERF_EN
      if (!ec[5] && m_sc != 16'hFFFF) m_sc <= m_sc + 16'd1;
      if ((ec[2] || ec[1]) && m_fc != 16'hFFFF) m_fc <= m_fc + 16'd1;
`endif
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic quiet();
    mv = 16'h0; RegWriteM = 0; RegWrite2M = 0; RegWriteW = 0; RegWrite2W = 0;
    MemtoRegE = 0; BranchTakenE = 0; Match_12D_E = 0; MultiStartE = 0; MultiCyclesE = 4'd0;
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1; quiet();
    next_cycle();
    @(negedge clk);
    if (dutv !== expv) begin fails++; $display("FAIL reset_vec: got %h want %h", dutv, expv); end
    checks++;
    if ({StallF, StallD, StallE, FlushD, FlushE, FlushM, BusyE, StallCount, FlushCount} !== {7'b1110000, 32'h0}) begin
      fails++; $display("FAIL reset_state: got %b %h %h", {StallF, StallD, StallE, FlushD, FlushE, FlushM, BusyE}, StallCount, FlushCount);
    end
    checks++;
    // hazards present while reset is held must not show on the outputs
    MemtoRegE = 1; Match_12D_E = 1; BranchTakenE = 1;
    @(negedge clk);
    if ({StallF, StallD, StallE, FlushD, FlushE, FlushM, BusyE} !== 7'b1110000) begin
      fails++; $display("FAIL reset_masks_hazard: got %b want 1110000", {StallF, StallD, StallE, FlushD, FlushE, FlushM, BusyE});
    end
    checks++;
    next_cycle();
    reset = 0; quiet();
    next_cycle();
  endtask

  task automatic test_fwd_priority();
    quiet();
    mv[0] = 1; mv[1] = 1; RegWriteM = 1; RegWriteW = 1;
    @(negedge clk);
    if (ForwardAE !== 3'd2) begin fails++; $display("FAIL fwd_M_over_W: got %0d want 2", ForwardAE); end
    checks++;
    RegWriteM = 0;
    @(negedge clk);
    if (ForwardAE !== 3'd1) begin fails++; $display("FAIL fwd_W: got %0d want 1", ForwardAE); end
    checks++;
    quiet(); mv[3] = 1; RegWrite2W = 1;
    @(negedge clk);
    if (ForwardAE !== 3'd4) begin fails++; $display("FAIL fwd_W0: got %0d want 4", ForwardAE); end
    checks++;
    quiet(); mv[2] = 1; mv[1] = 1; RegWrite2M = 1; RegWriteW = 1;
    @(negedge clk);
    if (ForwardAE !== 3'd3) begin fails++; $display("FAIL fwd_M0_over_W: got %0d want 3", ForwardAE); end
    checks++;
    quiet();
    next_cycle();
  endtask

  task automatic test_fwd_random();
    for (int i = 0; i < 200; i++) begin
      quiet();
      mv = 16'($urandom);
      {RegWriteM, RegWrite2M, RegWriteW, RegWrite2W} = 4'($urandom);
      @(negedge clk);
      if (dutv !== expv) begin fails++; $display("FAIL fwd_random[%0d]: got %h want %h", i, dutv, expv); end
      checks++;
      if (ForwardAE > 3'd4 || ForwardBE > 3'd4 || ForwardCE > 3'd4 || ForwardDE > 3'd4) begin
        fails++; $display("FAIL fwd_code_range[%0d]: got %0d %0d %0d %0d", i, ForwardAE, ForwardBE, ForwardCE, ForwardDE);
      end
      checks++;
      next_cycle();
    end
  endtask

  task automatic test_load_use();
    quiet(); MemtoRegE = 1; Match_12D_E = 1;
    @(negedge clk);
    if ({StallF, StallD, StallE, FlushD, FlushE, FlushM} !== 6'b001010) begin
      fails++; $display("FAIL load_use: got %b want 001010", {StallF, StallD, StallE, FlushD, FlushE, FlushM});
    end
    checks++;
    if (dutv !== expv) begin fails++; $display("FAIL load_use_vec: got %h want %h", dutv, expv); end
    checks++;
    next_cycle();
    quiet();
    @(negedge clk);
    if ({StallF, StallD, StallE, FlushD, FlushE, FlushM} !== 6'b111000) begin
      fails++; $display("FAIL load_use_release: got %b want 111000", {StallF, StallD, StallE, FlushD, FlushE, FlushM});
    end
    checks++;
    next_cycle();
  endtask

  task automatic test_branch_vs_loaduse();
    quiet(); BranchTakenE = 1; MemtoRegE = 1; Match_12D_E = 1;
    @(negedge clk);
    if ({StallF, StallD, FlushD, FlushE} !== 4'b1111) begin
      fails++; $display("FAIL branch_wins: got %b want 1111", {StallF, StallD, FlushD, FlushE});
    end
    checks++;
    if (dutv !== expv) begin fails++; $display("FAIL branch_wins_vec: got %h want %h", dutv, expv); end
    checks++;
    next_cycle();
    quiet();
  endtask

  task automatic test_multicycle();
    quiet(); MultiStartE = 1; MultiCyclesE = 4'd4;
    @(negedge clk);
    if (BusyE !== 1'b0) begin fails++; $display("FAIL multi_start_cycle_busy: got %b want 0", BusyE); end
    checks++;
    next_cycle();
    for (int i = 1; i <= 4; i++) begin
      quiet();
      mv = 16'($urandom);
      {RegWriteM, RegWrite2M, RegWriteW, RegWrite2W} = 4'($urandom);
      if (i <= 3) begin BranchTakenE = 1; MemtoRegE = 1; Match_12D_E = 1; end
      @(negedge clk);
      if ({BusyE, FlushM, StallE, StallF, StallD, FlushD, FlushE} !== ((i <= 3) ? 7'b1100000 : 7'b0011100)) begin
        fails++; $display("FAIL multi_cycle[%0d]: got %b", i, {BusyE, FlushM, StallE, StallF, StallD, FlushD, FlushE});
      end
      checks++;
      if (dutv !== expv) begin fails++; $display("FAIL multi_vec[%0d]: got %h want %h", i, dutv, expv); end
      checks++;
      next_cycle();
    end
    quiet();
  endtask

  task automatic test_start_branch();
    quiet(); MultiStartE = 1; MultiCyclesE = 4'd3; BranchTakenE = 1;
    @(negedge clk);
    if ({FlushD, FlushE, BusyE} !== 3'b110) begin
      fails++; $display("FAIL start_branch_flush: got %b want 110", {FlushD, FlushE, BusyE});
    end
    checks++;
    next_cycle();
    quiet();
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      if (BusyE !== (i <= 2)) begin fails++; $display("FAIL start_branch_busy[%0d]: got %b", i, BusyE); end
      checks++;
      if (dutv !== expv) begin fails++; $display("FAIL start_branch_vec[%0d]: got %h want %h", i, dutv, expv); end
      checks++;
      next_cycle();
    end
  endtask

  task automatic test_reset_midbusy();
    quiet(); MultiStartE = 1; MultiCyclesE = 4'd8;
    next_cycle();
    quiet();
    @(negedge clk);
    if (BusyE !== 1'b1) begin fails++; $display("FAIL midbusy_busy1: got %b want 1", BusyE); end
    checks++;
    next_cycle();
    reset = 1;
    @(negedge clk);
    if ({StallF, StallD, StallE, FlushM, BusyE} !== 5'b11100) begin
      fails++; $display("FAIL midbusy_during_reset: got %b want 11100", {StallF, StallD, StallE, FlushM, BusyE});
    end
    checks++;
    next_cycle();
    reset = 0;
    @(negedge clk);
    if ({BusyE, StallCount, FlushCount} !== 33'h0) begin
      fails++; $display("FAIL midbusy_after_reset: got busy=%b sc=%h fc=%h", BusyE, StallCount, FlushCount);
    end
    checks++;
    if (dutv !== expv) begin fails++; $display("FAIL midbusy_vec: got %h want %h", dutv, expv); end
    checks++;
    next_cycle();
    for (int n = 0; n <= 1; n++) begin
      MultiStartE = 1; MultiCyclesE = 4'(n);
      for (int i = 0; i < 4; i++) begin
        @(negedge clk);
        if ({BusyE, StallF, StallD, StallE} !== 4'b0111) begin
          fails++; $display("FAIL single_cycle_n%0d[%0d]: got %b want 0111", n, i, {BusyE, StallF, StallD, StallE});
        end
        checks++;
        next_cycle();
        MultiStartE = 0;
      end
    end
    quiet();
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      mv = 16'($urandom);
      {RegWriteM, RegWrite2M, RegWriteW, RegWrite2W} = 4'($urandom);
      MemtoRegE    = 1'($urandom);
      Match_12D_E  = 1'($urandom);
      BranchTakenE = ($urandom_range(0, 5) == 0);
      MultiStartE  = ($urandom_range(0, 7) == 0);
      MultiCyclesE = 4'($urandom_range(0, 15));
      reset        = ($urandom_range(0, 63) == 0);
      @(negedge clk);
      if (dutv !== expv) begin fails++; $display("FAIL random[%0d]: got %h want %h", i, dutv, expv); end
      checks++;
      next_cycle();
    end
    reset = 0; quiet();
    repeat (16) next_cycle();
  endtask

  task automatic test_saturation();
    logic [15:0] want;
`ifdef HAZARD_PERF_EN
    want = 16'hFFFF;
`else
    want = 16'h0000;
`endif
    quiet(); MemtoRegE = 1; Match_12D_E = 1;
    repeat (70000) @(posedge clk);
    #1;
    @(negedge clk);
    if (StallCount !== want) begin fails++; $display("FAIL stall_count_sat: got %h want %h", StallCount, want); end
    checks++;
    if (FlushCount !== want) begin fails++; $display("FAIL flush_count_sat: got %h want %h", FlushCount, want); end
    checks++;
    if (dutv !== expv) begin fails++; $display("FAIL sat_vec: got %h want %h", dutv, expv); end
    checks++;
    next_cycle();
    quiet();
  endtask

  initial begin
    reset = 1; quiet();
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_fwd_priority();
    test_fwd_random();
    test_load_use();
    test_branch_vs_loaduse();
    test_multicycle();
    test_start_branch();
    test_reset_midbusy();
    test_random();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
